regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with an integrated busy-bit scoreboard, for the next-generation RISC-V core.
- Generalises the single-write/two-read file to NRD read ports and two prioritised write ports (WB0 = ALU, WB1 = load/long-latency).
- Tracks in-flight producers per register so decode can stall on RAW hazards.
- x0 is hardwired to zero.

Parameters:
XLEN, 32, data width of each register.
NREG, 32, number of architectural registers including x0 (power of two, >= 2).
NRD, 2, number of combinational read ports (1..4).
AW, $clog2(NREG), localparam, register index width; not overridable.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous active-high reset.
rd_addr  in  NRD*AW  packed read indices; port i uses bits [i*AW +: AW].
rd_data  out  NRD*XLEN  packed read data, combinational from rd_addr.
rd_busy  out  NRD  per-port scoreboard busy flag for the register being read.
wr0_en  in  1  write enable, port 0.
wr0_addr  in  AW  write index, port 0.
wr0_data  in  XLEN  write data, port 0.
wr1_en  in  1  write enable, port 1.
wr1_addr  in  AW  write index, port 1.
wr1_data  in  XLEN  write data, port 1.
sb_set_en  in  1  mark a destination register busy (instruction issued).
sb_set_addr  in  AW  register to mark busy.
sb_cnt  out  $clog2(NREG+1)  registered count of busy registers.
sb_any  out  1  registered flag, sb_cnt != 0.

Behaviour:
- Reset: one cycle of rst=1 clears every register and every busy bit at the next edge; sb_cnt=0, sb_any=0. rd_data then reads 0 and rd_busy reads 0. Writes and sets are ignored while rst=1; reset wins over every same-cycle event.
- Reads: rd_data[i] = reg[rd_addr[i]], zero latency. Index 0 always returns 0 and rd_busy=0.
- Writes: committed at the rising edge when the port's enable is 1.
  - Writes to index 0 are discarded.
  - wr0 and wr1 to the same nonzero index in the same cycle: wr1 wins and one write occurs.
- Scoreboard:
  - busy[n] is set at the edge when sb_set_en=1 and sb_set_addr=n, n != 0.
  - busy[n] is cleared at the edge when either write port commits to n.
  - Set and clear of the same n in the same cycle: set wins, because a newer producer was issued. busy stays 1.
  - Set of an already-busy register: stays 1 with no count change.
  - Clear of a non-busy register: no effect.
  - rd_busy[i] = busy[rd_addr[i]].
- Counter: sb_cnt updates at the same edge as the busy vector. It is the popcount of the next-state busy vector, held in a register, and never exceeds NREG-1. sb_any is registered alongside it.
- No other state; no handshakes. The stall decision belongs to the caller.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If wrX_en is active and wrX_addr equals rd_addr[i] != 0 in the same cycle, rd_data[i] returns that write's data, with wr1 taking priority.
  - rd_busy[i] is forced 0 unless sb_set_en targets the same index that cycle.
  - Read-after-write latency is 0 cycles.
- Undefined: rd_data and rd_busy reflect pre-edge state; the new value is visible one cycle after the write. Latency is 1 cycle.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEFAULT = 32 and NREG_DEFAULT = 32
  - REG_ZERO = 0
  - the write-port priority constant WR_PRIO_PORT = 1
  - a function popcount sized by NREG
- One sub-module, regfile_scoreboard, holds the busy vector, set/clear arbitration, sb_cnt and sb_any. It takes clk, rst, the set port, the two write enables and addresses, and returns the busy vector.
- The data array and read muxes stay in the top level.

Test Plan:
- Reset then read: rst=1 for 1 cycle, then read x5 and x31 -> rd_data=0, rd_busy=0, sb_cnt=0.
- Dual write collision: wr0 x3=0xAAAA0000 and wr1 x3=0x5555FFFF in the same cycle -> next cycle x3 reads 0x5555FFFF. A write of 0xDEADBEEF to x0 -> x0 still reads 0.
- Scoreboard set/clear: set x7 -> next cycle rd_busy=1, sb_cnt=1; wr1 x7=0x12 -> next cycle rd_busy=0, sb_cnt=0, read returns 0x12.
- Simultaneous set and clear: x9 busy, then wr0 x9 and sb_set x9 in the same cycle -> x9 stays busy, sb_cnt unchanged, data updated.
- Bypass: same-cycle write x4=0x77 and read x4.
  - With REGFILE_BYPASS_EN: rd_data=0x77 that cycle.
  - Without: old value that cycle, 0x77 next cycle.
- Reset mid-operation: busy x1..x10 (sb_cnt=10), then assert rst alongside wr0 x2=0x1 -> next cycle all zero, sb_cnt=0, sb_any=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Shared constants and the popcount helper for the multi-port register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int REG_ZERO     = 0;
  localparam int WR_PRIO_PORT = 1;

  // Upper bound on NREG the popcount helper supports; unused high bits fold away.
  localparam int NREG_MAX = 256;
  localparam int PC_W     = $clog2(NREG_MAX + 1);

  function automatic logic [PC_W-1:0] popcount(input logic [NREG_MAX-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREG_MAX; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module : regfile_scoreboard
// Busy-bit scoreboard: set on issue, clear on writeback, set beats clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  localparam int AW  = $clog2(NREG),
  localparam int CW  = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sb_set_en,
  input  logic [AW-1:0]   sb_set_addr,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   sb_cnt,
  output logic            sb_any
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            any_q, any_d;
  logic [PC_W-1:0] cnt_full;

  always_comb begin
    busy_d = busy_q;
    if (wr0_en && wr0_addr != ZERO_IDX) busy_d[wr0_addr] = 1'b0;
    if (wr1_en && wr1_addr != ZERO_IDX) busy_d[wr1_addr] = 1'b0;
    // Applied last so a newly issued producer outranks a retiring older one.
    if (sb_set_en && sb_set_addr != ZERO_IDX) busy_d[sb_set_addr] = 1'b1;
    busy_d[ZERO_IDX] = 1'b0;
    cnt_full = popcount(NREG_MAX'(busy_d));
    cnt_d    = CW'(cnt_full);
    any_d    = |busy_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      any_q  <= any_d;
    end
  end

  assign busy   = busy_q;
  assign sb_cnt = cnt_q;
  assign sb_any = any_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp_sb.sv
// ============================================================================
// Module : regfile_mp_sb
// Multi-read, dual-write integer register file with busy-bit scoreboard.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through reads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD*AW-1:0]        rd_addr,
  output logic [NRD*XLEN-1:0]      rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     wr0_en,
  input  logic [AW-1:0]            wr0_addr,
  input  logic [XLEN-1:0]          wr0_data,
  input  logic                     wr1_en,
  input  logic [AW-1:0]            wr1_addr,
  input  logic [XLEN-1:0]          wr1_data,
  input  logic                     sb_set_en,
  input  logic [AW-1:0]            sb_set_addr,
  output logic [$clog2(NREG+1)-1:0] sb_cnt,
  output logic                     sb_any
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);
  localparam bit            WR_HI    = 1'(WR_PRIO_PORT);
  localparam bit            WR_LO    = ~WR_HI;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy;
  logic [AW-1:0]   rd_idx [NRD];

  logic            wen   [2];
  logic [AW-1:0]   waddr [2];
  logic [XLEN-1:0] wdata [2];

  assign wen[0]   = wr0_en;
  assign wen[1]   = wr1_en;
  assign waddr[0] = wr0_addr;
  assign waddr[1] = wr1_addr;
  assign wdata[0] = wr0_data;
  assign wdata[1] = wr1_data;

  regfile_scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .sb_set_en  (sb_set_en),
    .sb_set_addr(sb_set_addr),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .busy       (busy),
    .sb_cnt     (sb_cnt),
    .sb_any     (sb_any)
  );

  // Lower-priority port applied first so the priority port overwrites on collision.
  always_comb begin
    regs_d = regs_q;
    if (wen[WR_LO] && waddr[WR_LO] != ZERO_IDX) regs_d[waddr[WR_LO]] = wdata[WR_LO];
    if (wen[WR_HI] && waddr[WR_HI] != ZERO_IDX) regs_d[waddr[WR_HI]] = wdata[WR_HI];
    regs_d[ZERO_IDX] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) regs_q[n] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd_idx
    assign rd_idx[i] = rd_addr[i*AW +: AW];
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs_q[rd_idx[i]];
      rd_busy[i]              = busy[rd_idx[i]];
`ifdef REGFILE_BYPASS_EN
      if (rd_idx[i] != ZERO_IDX) begin
        if (wen[WR_HI] && waddr[WR_HI] == rd_idx[i]) begin
          rd_data[i*XLEN +: XLEN] = wdata[WR_HI];
        end else if (wen[WR_LO] && waddr[WR_LO] == rd_idx[i]) begin
          rd_data[i*XLEN +: XLEN] = wdata[WR_LO];
        end
        // A retiring write clears busy unless a new producer claims it this cycle.
        if ((wr0_en && wr0_addr == rd_idx[i]) || (wr1_en && wr1_addr == rd_idx[i])) begin
          rd_busy[i] = sb_set_en && (sb_set_addr == rd_idx[i]);
        end
      end
`endif
    end
  end

endmodule

`default_nettype wire
